// File: rtl/music_track_sequencer.sv
// Four-track score player: fetches entries from a synchronous score ROM and
// holds each entry's four note codes for its duration in ticks.
module music_track_sequencer #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TICK_DIV = 1000000,
  parameter bit          LOOP     = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [5:0]        track0,
  output logic [5:0]        track1,
  output logic [5:0]        track2,
  output logic [5:0]        track3,
  output logic              playing,
  output logic              done,
  output logic              tick
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       trk_q, trk_d;
  logic [7:0]        dur_q, dur_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      trk_q      <= '0;
      dur_q      <= '0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      trk_q      <= trk_d;
      dur_q      <= dur_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Next-state, datapath updates and the done/tick pulses (stop overrides all).
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    trk_d      = trk_q;
    dur_d      = dur_q;
    tick_cnt_d = tick_cnt_q;
    done       = 1'b0;
    tick       = 1'b0;
    if (stop) begin
      state_d    = S_IDLE;
      addr_d     = '0;
      trk_d      = '0;
      dur_d      = '0;
      tick_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          trk_d = '0;
          if (start) begin
            addr_d  = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          if (rom_data[31:24] != 8'd0) begin
            trk_d      = rom_data[23:0];
            dur_d      = rom_data[31:24];
            tick_cnt_d = '0;
            addr_d     = addr_q + ADDR_W'(1);
            state_d    = S_PLAY;
          end else if (LOOP) begin
            addr_d  = '0;
            state_d = S_FETCH;
          end else begin
            trk_d   = '0;
            done    = 1'b1;
            state_d = S_DONE;
          end
        end
        S_PLAY: begin
          if (!pause) begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_d = '0;
              tick       = 1'b1;
              dur_d      = dur_q - 8'd1;
              if (dur_q == 8'd1) begin
                state_d = S_FETCH;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + TW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rom_addr = addr_q;
  assign track0   = trk_q[5:0];
  assign track1   = trk_q[11:6];
  assign track2   = trk_q[17:12];
  assign track3   = trk_q[23:18];
  assign playing  = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_PLAY);

endmodule

// File: doc/music_track_sequencer.md
Name: music_track_sequencer

Overview:
- Plays a stored 4-track score in real time. Fetches score entries from a synchronous score ROM and holds each entry's four note codes for that entry's duration.
- Drives the 6-bit track0..track3 buses consumed directly by the light/note decoding stage in MusicView.
- Note code 0 = rest. Codes pass through unmodified; no range checking.

Parameters:
- ADDR_W, 8, score ROM address width (max 2^ADDR_W entries).
- TICK_DIV, 1000000, clk cycles per duration tick (10 ms at 100 MHz); must be >= 2.
- LOOP, 0, 1 = restart at address 0 on end marker; 0 = stop and pulse done.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level-sampled; begins playback from address 0 when in IDLE or DONE
- stop  in  1  aborts playback; highest priority
- pause  in  1  level; freezes playback while high (PLAY state only)
- rom_addr  out  ADDR_W  registered score ROM address
- rom_data  in  32  ROM word, valid one clk after rom_addr changes; [5:0] trk0, [11:6] trk1, [17:12] trk2, [23:18] trk3, [31:24] duration in ticks (0 = end marker)
- track0..track3  out  6 each  current note codes to the decoder
- playing  out  1  high in FETCH, LOAD, PLAY
- done  out  1  one-cycle pulse on reaching end marker with LOOP=0
- tick  out  1  one-cycle pulse on each duration tick in PLAY (for display sync)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rom_addr=0, track0..3=0, playing=0, done=0, tick=0, internal counters=0.
- States: IDLE, FETCH, LOAD, PLAY, DONE.
- IDLE/DONE:
  - Tracks=0.
  - start=1 and stop=0 -> rom_addr<=0, go to FETCH.
- FETCH: wait one cycle for ROM data; rom_addr stable; tracks hold previous values. Next state is LOAD.
- LOAD: sample rom_data.
  - duration!=0: tracks<=note fields; dur_cnt<=duration; tick_cnt<=0; rom_addr<=rom_addr+1 (wraps 2^ADDR_W-1 -> 0); go to PLAY.
  - duration==0, LOOP=1: rom_addr<=0; go to FETCH; tracks hold.
  - duration==0, LOOP=0: tracks<=0; done=1 for this transition cycle only; go to DONE.
- PLAY:
  - pause=0: tick_cnt increments; at TICK_DIV-1 it wraps to 0, tick pulses, and dur_cnt decrements. If dur_cnt was 1 at that wrap, go to FETCH.
  - pause=1: tick_cnt and dur_cnt frozen; tracks held; tick=0.
- Timing:
  - start sampled at edge N -> FETCH at N+1, LOAD at N+2. First notes are visible after edge N+3.
  - Each entry is visible for duration*TICK_DIV cycles in PLAY, plus 2 cycles (FETCH+LOAD) before the next entry replaces it.
- stop=1 in any state: next edge -> IDLE, tracks=0, rom_addr=0, counters cleared, done not pulsed. stop wins over simultaneous start.
- start while FETCH/LOAD/PLAY: ignored.
- pause during FETCH/LOAD: ignored; the load completes and playback freezes on entry to PLAY.
- Empty score (entry 0 is an end marker), LOOP=0: done pulses at edge N+2; no non-zero track output.
- Empty score with LOOP=1: cycles FETCH/LOAD indefinitely with tracks=0 and playing=1; this is legal.
- Reset mid-operation: immediate return to reset values regardless of state.

Test Plan:
- Basic playback (TICK_DIV=4, LOOP=0). ROM[0]={dur 2, trk0=5}, ROM[1]={dur 1, trk1=12, trk3=1}, ROM[2]=end. Pulse start -> track0=5 for 8+2 cycles, then track1=12/track3=1 for 4+2 cycles, then all tracks 0. done pulses once, playing falls, 3 tick pulses total.
- LOOP=1 with the same ROM -> after ROM[2], rom_addr returns to 0. track0=5 reappears 2 cycles after the end-marker LOAD; done is never asserted.
- Pause: hold pause high for 10 cycles mid-entry 0 -> track0 stays 5, no tick pulses; entry 0's total visible time extends by exactly 10 cycles.
- Stop mid-PLAY with start asserted in the same cycle -> next cycle: IDLE, tracks=0, rom_addr=0, playing=0, done=0.
- Empty score (ROM[0] end marker), LOOP=0 -> done at start+2 cycles; tracks remain 0 throughout.
- Async reset: drop rst_n mid-PLAY between clock edges -> outputs go to reset values immediately. After release, a new start replays from address 0.
